// File: rtl/vram_copy_ctrl_if.sv
// Bus bundle between the VRAM block-copy controller and the SoC: CPU config port,
// BUSRQ/BUSAK handshake, source read port and video RAM write port.
interface vram_copy_ctrl_if #(
  parameter int SRC_AW = 16,
  parameter int DST_AW = 14
);
  logic              cfg_wr;
  logic [2:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic              busrq_n;
  logic              busak_n;
  logic              src_rd;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_wr;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        dst_data;
  logic              progress;
  logic              done;

  modport master (
    input  cfg_wr, cfg_addr, cfg_data, busak_n, src_data,
    output busrq_n, src_rd, src_addr, dst_wr, dst_addr, dst_data, progress, done
  );

  modport slave (
    output cfg_wr, cfg_addr, cfg_data, busak_n, src_data,
    input  busrq_n, src_rd, src_addr, dst_wr, dst_addr, dst_data, progress, done
  );
endinterface

// File: rtl/vram_copy_ctrl.sv
// Bus-mastering block copy from CPU address space into video RAM, one byte per clock
// once the CPU has granted the bus.
module vram_copy_ctrl #(
  parameter int SRC_AW = 16,
  parameter int DST_AW = 14
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  vram_copy_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;

  state_t            state_q;
  logic [SRC_AW-1:0] srcReg_q;
  logic [DST_AW-1:0] dstReg_q;
  logic [13:0]       lenReg_q;
  logic [SRC_AW-1:0] curSrc_q, curSrc_d;
  logic [DST_AW-1:0] curDst_q, curDst_d;
  logic [13:0]       rdLeft_q, rdLeft_d;
  logic [13:0]       wrLeft_q, wrLeft_d;
  logic              busrqN_q;
  logic              srcRd_q;
  logic [SRC_AW-1:0] srcAddr_q;
  logic              dstWr_q;
  logic [DST_AW-1:0] dstAddr_q;
  logic              progress_q;
  logic              done_q;
  logic              startReq;

  always_comb begin
    curSrc_d = curSrc_q + SRC_AW'(1);
    curDst_d = curDst_q + DST_AW'(1);
    rdLeft_d = rdLeft_q - 14'd1;
    wrLeft_d = wrLeft_q - 14'd1;
    startReq = bus.cfg_wr && (bus.cfg_addr == 3'd6) && bus.cfg_data[0];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      srcReg_q   <= '0;
      dstReg_q   <= '0;
      lenReg_q   <= '0;
      curSrc_q   <= '0;
      curDst_q   <= '0;
      rdLeft_q   <= '0;
      wrLeft_q   <= '0;
      busrqN_q   <= 1'b1;
      srcRd_q    <= 1'b0;
      srcAddr_q  <= '0;
      dstWr_q    <= 1'b0;
      dstAddr_q  <= '0;
      progress_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      srcRd_q <= 1'b0;
      dstWr_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busrqN_q   <= 1'b1;
          progress_q <= 1'b0;
          if (bus.cfg_wr) begin
            case (bus.cfg_addr)
              3'd0: srcReg_q <= {srcReg_q[SRC_AW-1:8], bus.cfg_data};
              3'd1: srcReg_q <= SRC_AW'({bus.cfg_data, srcReg_q[7:0]});
              3'd2: dstReg_q <= {dstReg_q[DST_AW-1:8], bus.cfg_data};
              3'd3: dstReg_q <= DST_AW'({bus.cfg_data, dstReg_q[7:0]});
              3'd4: lenReg_q <= {lenReg_q[13:8], bus.cfg_data};
              3'd5: lenReg_q <= 14'({bus.cfg_data, lenReg_q[7:0]});
              default: ;
            endcase
          end
          if (startReq) begin
            progress_q <= 1'b1;
            if (lenReg_q != 14'd0) begin
              curSrc_q <= srcReg_q;
              curDst_q <= dstReg_q;
              rdLeft_q <= lenReg_q;
              wrLeft_q <= lenReg_q;
              busrqN_q <= 1'b0;
              state_q  <= REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= REL;
            end
          end
        end
        REQ: begin
          // Grant edge already issues the first read so it appears right after BUSAK.
          if (!bus.busak_n) begin
            state_q   <= COPY;
            srcRd_q   <= 1'b1;
            srcAddr_q <= curSrc_q;
            curSrc_q  <= curSrc_d;
            rdLeft_q  <= rdLeft_d;
          end
        end
        COPY: begin
          if (rdLeft_q != 14'd0) begin
            srcRd_q   <= 1'b1;
            srcAddr_q <= curSrc_q;
            curSrc_q  <= curSrc_d;
            rdLeft_q  <= rdLeft_d;
          end
          if (srcRd_q) begin
            dstWr_q   <= 1'b1;
            dstAddr_q <= curDst_q;
            curDst_q  <= curDst_d;
            wrLeft_q  <= wrLeft_d;
          end else if (dstWr_q && (wrLeft_q == 14'd0)) begin
            busrqN_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= REL;
          end
        end
        REL: begin
          busrqN_q   <= 1'b1;
          progress_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The source RAM output is itself a register, so it feeds the write port directly.
  assign bus.dst_data = dstWr_q ? bus.src_data : 8'h00;
  assign bus.busrq_n  = busrqN_q;
  assign bus.src_rd   = srcRd_q;
  assign bus.src_addr = srcAddr_q;
  assign bus.dst_wr   = dstWr_q;
  assign bus.dst_addr = dstAddr_q;
  assign bus.progress = progress_q;
  assign bus.done     = done_q;

endmodule
